// File: rtl/seq_divider.sv
// ---------------------------------------------------------------------------
// seq_divider
//
// Unsigned restoring shift-subtract divider.
// - Produces one quotient bit per clock, MSB first.
// - A result takes DATA_WIDTH cycles in CALC plus one cycle in DONE.
// - A zero divisor skips CALC. It goes straight to DONE with the result
//   quotient = all ones, remainder = dividend, div_by_zero = 1.
//
// Ports
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   start        in   division request, sampled only while ready=1
//   dividend     in   DATA_WIDTH  unsigned numerator, captured on accept
//   divisor      in   DATA_WIDTH  unsigned denominator, captured on accept
//   ready        out  high in IDLE only
//   done         out  one-cycle pulse while results are fresh
//   quotient     out  DATA_WIDTH  registered quotient, held until next DONE
//   remainder    out  DATA_WIDTH  registered remainder, held until next DONE
//   div_by_zero  out  registered flag for the last result
//
// State | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; ready=1
// CALC  | one shift-subtract iteration per cycle, cnt_q counts down
// DONE  | results loaded on entry; done=1 for this single cycle
// ---------------------------------------------------------------------------
module seq_divider #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic                  ready,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] quotient,
    output logic [DATA_WIDTH-1:0] remainder,
    output logic                  div_by_zero
);

    localparam int DW    = DATA_WIDTH;
    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CNT_W-1:0] cnt_q,  cnt_d;
    logic [DW-1:0]   rem_q,  rem_d;    // partial remainder between iterations
    logic [DW-1:0]   dvd_q,  dvd_d;    // dividend bits shift out, quotient bits shift in
    logic [DW-1:0]   dvs_q,  dvs_d;
    logic [DW-1:0]   quo_q,  quo_d;
    logic [DW-1:0]   rmd_q,  rmd_d;
    logic            dbz_q,  dbz_d;

    logic [DW:0]     part;
    logic [DW:0]     diff;
    logic            qbit;
    logic [DW-1:0]   rem_step;
    logic [DW-1:0]   dvd_step;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            quo_q   <= '0;
            rmd_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
            dbz_q   <= dbz_d;
        end
    end

    // One iteration of the shift-subtract step. The result is only used in CALC.
    // - The remainder held in rem_q is always below the divisor.
    // - So part stays below 2*divisor, and part - divisor fits in DW bits
    //   whenever it does not borrow.
    // - Bit DW of the difference is therefore exactly the borrow flag.
    always_comb begin
        part     = {rem_q, dvd_q[DW-1]};
        diff     = part - {1'b0, dvs_q};
        qbit     = ~diff[DW];
        rem_step = qbit ? diff[DW-1:0] : part[DW-1:0];
        dvd_step = {dvd_q[DW-2:0], qbit};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        rmd_d   = rmd_q;
        dbz_d   = dbz_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (divisor == '0) begin
                        state_d = DONE;
                        quo_d   = '1;
                        rmd_d   = dividend;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = CALC;
                        dvd_d   = dividend;
                        dvs_d   = divisor;
                        rem_d   = '0;
                        cnt_d   = CNT_W'(DW);
                    end
                end
            end
            CALC: begin
                rem_d = rem_step;
                dvd_d = dvd_step;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                    quo_d   = dvd_step;
                    rmd_d   = rem_step;
                    dbz_d   = 1'b0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ready       = (state_q == IDLE);
    assign done        = (state_q == DONE);
    assign quotient    = quo_q;
    assign remainder   = rmd_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] dividend = 8'd0;
    logic [7:0] divisor = 8'd0;
    logic       ready;
    logic       done;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_by_zero;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;

    seq_divider #(.DATA_WIDTH(8)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .dividend(dividend),
        .divisor(divisor),
        .ready(ready),
        .done(done),
        .quotient(quotient),
        .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents operands with start=1 and steps past the accepting edge.
    task automatic do_start(input logic [7:0] a, input logic [7:0] b);
        start = 1'b1;
        dividend = a;
        divisor = b;
        tick();
        start = 1'b0;
    endtask

    // Returns the number of edges until done is seen, or -1 if done never arrives.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) begin
                lat = i;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", ready); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (quotient !== 8'd0) begin bad++; $display("FAIL reset_q got=%0d exp=0", quotient); end
        total++; if (remainder !== 8'd0) begin bad++; $display("FAIL reset_r got=%0d exp=0", remainder); end
        total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL reset_dbz got=%b exp=0", div_by_zero); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int d0;
        d0 = done_cnt;
        do_start(8'd100, 8'd7);
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL basic_ready_k got=%b exp=0", ready); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_done_k got=%b exp=0", done); end
        for (int i = 1; i <= 9; i++) begin
            tick();
            total++; if (done !== 1'(i == 8)) begin bad++; $display("FAIL basic_done_k+%0d got=%b exp=%b", i, done, (i == 8)); end
            total++; if (ready !== 1'(i == 9)) begin bad++; $display("FAIL basic_ready_k+%0d got=%b exp=%b", i, ready, (i == 9)); end
            if (i == 8) begin
                total++; if (quotient !== 8'd14) begin bad++; $display("FAIL basic_q got=%0d exp=14", quotient); end
                total++; if (remainder !== 8'd2) begin bad++; $display("FAIL basic_r got=%0d exp=2", remainder); end
                total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL basic_dbz got=%b exp=0", div_by_zero); end
            end
        end
        total++; if (quotient !== 8'd14) begin bad++; $display("FAIL basic_q_hold got=%0d exp=14", quotient); end
        total++; if (remainder !== 8'd2) begin bad++; $display("FAIL basic_r_hold got=%0d exp=2", remainder); end
        total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL basic_pulses got=%0d exp=1", done_cnt - d0); end
    endtask

    task automatic test_values();
        logic [7:0] ta [3];
        logic [7:0] tb [3];
        logic [7:0] tq [3];
        logic [7:0] tr [3];
        int lat;
        ta = '{8'd255, 8'd5, 8'd255};
        tb = '{8'd1,   8'd9, 8'd255};
        tq = '{8'd255, 8'd0, 8'd1};
        tr = '{8'd0,   8'd5, 8'd0};
        for (int i = 0; i < 3; i++) begin
            do_start(ta[i], tb[i]);
            wait_done(lat);
            total++; if (lat !== 8) begin bad++; $display("FAIL values%0d_lat got=%0d exp=8", i, lat); end
            total++; if (quotient !== tq[i]) begin bad++; $display("FAIL values%0d_q got=%0d exp=%0d", i, quotient, tq[i]); end
            total++; if (remainder !== tr[i]) begin bad++; $display("FAIL values%0d_r got=%0d exp=%0d", i, remainder, tr[i]); end
            total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL values%0d_dbz got=%b exp=0", i, div_by_zero); end
            tick();
        end
    endtask

    task automatic test_div_zero();
        int lat;
        do_start(8'd37, 8'd0);
        wait_done(lat);
        total++; if (lat !== 0) begin bad++; $display("FAIL dbz_lat got=%0d exp=0", lat); end
        total++; if (quotient !== 8'd255) begin bad++; $display("FAIL dbz_q got=%0d exp=255", quotient); end
        total++; if (remainder !== 8'd37) begin bad++; $display("FAIL dbz_r got=%0d exp=37", remainder); end
        total++; if (div_by_zero !== 1'b1) begin bad++; $display("FAIL dbz_flag got=%b exp=1", div_by_zero); end
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL dbz_ready_done got=%b exp=0", ready); end
        tick();
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL dbz_ready_idle got=%b exp=1", ready); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL dbz_done_low got=%b exp=0", done); end
        repeat (3) tick();
        total++; if (quotient !== 8'd255) begin bad++; $display("FAIL dbz_q_hold got=%0d exp=255", quotient); end
        total++; if (div_by_zero !== 1'b1) begin bad++; $display("FAIL dbz_flag_hold got=%b exp=1", div_by_zero); end
        do_start(8'd12, 8'd5);
        wait_done(lat);
        total++; if (lat !== 8) begin bad++; $display("FAIL dbz_next_lat got=%0d exp=8", lat); end
        total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL dbz_cleared got=%b exp=0", div_by_zero); end
        total++; if (quotient !== 8'd2) begin bad++; $display("FAIL dbz_next_q got=%0d exp=2", quotient); end
        total++; if (remainder !== 8'd2) begin bad++; $display("FAIL dbz_next_r got=%0d exp=2", remainder); end
        tick();
    endtask

    task automatic test_ignore_start();
        int d0;
        int lat;
        d0 = done_cnt;
        do_start(8'd100, 8'd7);
        start = 1'b1;
        dividend = 8'd200;
        divisor = 8'd3;
        repeat (3) tick();
        start = 1'b0;
        wait_done(lat);
        total++; if (lat !== 5) begin bad++; $display("FAIL ignore_lat got=%0d exp=5", lat); end
        total++; if (quotient !== 8'd14) begin bad++; $display("FAIL ignore_q got=%0d exp=14", quotient); end
        total++; if (remainder !== 8'd2) begin bad++; $display("FAIL ignore_r got=%0d exp=2", remainder); end
        repeat (12) tick();
        total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL ignore_pulses got=%0d exp=1", done_cnt - d0); end
    endtask

    task automatic test_reset_mid();
        int d0;
        int lat;
        d0 = done_cnt;
        do_start(8'd100, 8'd7);
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready got=%b exp=1", ready); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rstmid_done got=%b exp=0", done); end
        total++; if (quotient !== 8'd0) begin bad++; $display("FAIL rstmid_q got=%0d exp=0", quotient); end
        total++; if (remainder !== 8'd0) begin bad++; $display("FAIL rstmid_r got=%0d exp=0", remainder); end
        total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL rstmid_dbz got=%b exp=0", div_by_zero); end
        tick();
        tick();
        rst_n = 1'b1;
        repeat (12) tick();
        total++; if (done_cnt !== d0) begin bad++; $display("FAIL rstmid_pulses got=%0d exp=%0d", done_cnt, d0); end
        do_start(8'd200, 8'd3);
        wait_done(lat);
        total++; if (lat !== 8) begin bad++; $display("FAIL rstmid_next_lat got=%0d exp=8", lat); end
        total++; if (quotient !== 8'd66) begin bad++; $display("FAIL rstmid_next_q got=%0d exp=66", quotient); end
        total++; if (remainder !== 8'd2) begin bad++; $display("FAIL rstmid_next_r got=%0d exp=2", remainder); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] eq;
        logic [7:0] er;
        int lat;
        int recon;
        a = 8'($urandom_range(0, 255));
        b = 8'($urandom_range(1, 255));
        start = 1'b1;
        dividend = a;
        divisor = b;
        for (int n = 0; n < 1000; n++) begin
            // start stays high; from the IDLE cycle the next accept is one edge away
            wait_done(lat);
            eq = a / b;
            er = a % b;
            recon = int'(quotient) * int'(b) + int'(remainder);
            total++; if (lat !== 9) begin bad++; $display("FAIL b2b%0d_period got=%0d exp=9", n, lat); end
            total++; if (quotient !== eq) begin bad++; $display("FAIL b2b%0d_q %0d/%0d got=%0d exp=%0d", n, a, b, quotient, eq); end
            total++; if (remainder !== er) begin bad++; $display("FAIL b2b%0d_r %0d/%0d got=%0d exp=%0d", n, a, b, remainder, er); end
            total++; if (recon !== int'(a)) begin bad++; $display("FAIL b2b%0d_identity got=%0d exp=%0d", n, recon, a); end
            total++; if ((remainder < b) !== 1'b1) begin bad++; $display("FAIL b2b%0d_rem_lt_div got=%0d exp<%0d", n, remainder, b); end
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(1, 255));
            dividend = a;
            divisor = b;
            tick();
        end
        start = 1'b0;
        repeat (12) tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_values();
        test_div_zero();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
